// File: rtl/ysyx_23060025_wbu_buf.sv
// Writeback buffer: DEPTH-entry in-order queue between the LSU and the RF/CSR side,
// with bypass forwarding of buffered results, a retire counter and a sticky ebreak halt.
module ysyx_23060025_wbu_buf #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32,
  parameter int DEPTH    = 2,
  parameter int CNT_LEN  = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ms_to_ws_valid,
  output logic                ws_allowin_o,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  input  logic [DATA_LEN-1:0] reg_wdata_i,
  input  logic [2:0]          csr_type_i,
  input  logic [11:0]         csr_waddr_i,
  input  logic [DATA_LEN-1:0] csr_wdata_i,
  input  logic [DATA_LEN-1:0] csr_mcause_i,
  input  logic [ADDR_LEN-1:0] pc_i,
  input  logic                ebreak_flag_i,
  input  logic                rf_ready_i,
  output logic                commit_valid_o,
  output logic [ADDR_LEN-1:0] commit_pc_o,
  output logic                wd_o,
  output logic [4:0]          wreg_o,
  output logic [DATA_LEN-1:0] wdata_o,
  output logic [2:0]          csr_type_o,
  output logic [11:0]         csr_waddr_o,
  output logic [DATA_LEN-1:0] csr_wdata_o,
  output logic [DATA_LEN-1:0] csr_mcause_o,
  output logic                ebreak_o,
  output logic [CNT_LEN-1:0]  retire_cnt_o,
  input  logic [4:0]          fwd_raddr_i,
  output logic                fwd_hit_o,
  output logic [DATA_LEN-1:0] fwd_data_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} state_e;

  typedef struct packed {
    logic                wd;
    logic [4:0]          wreg;
    logic [DATA_LEN-1:0] reg_wdata;
    logic [2:0]          csr_type;
    logic [11:0]         csr_waddr;
    logic [DATA_LEN-1:0] csr_wdata;
    logic [DATA_LEN-1:0] csr_mcause;
    logic [ADDR_LEN-1:0] pc;
    logic                ebreak;
  } entry_t;

  entry_t               buf_q [DEPTH];
  entry_t               buf_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  state_e               state_q, state_d;
  logic                 ebreak_q, ebreak_d;
  logic [CNT_LEN-1:0]   retire_cnt_q, retire_cnt_d;

  entry_t               head_s;
  entry_t               in_entry_s;
  logic                 enq_s;
  logic                 deq_s;
  logic                 fwd_hit_s;
  logic [DATA_LEN-1:0]  fwd_data_s;

  // Head view and handshake qualifiers, all derived from registered state only.
  always_comb begin
    head_s         = buf_q[rd_ptr_q];
    ws_allowin_o   = (state_q == ST_RUN) && (count_q < CNT_W'(DEPTH));
    commit_valid_o = (count_q != CNT_W'(0)) && (state_q == ST_RUN);
    enq_s          = ms_to_ws_valid && ws_allowin_o;
    deq_s          = commit_valid_o && rf_ready_i;
    in_entry_s     = '{wd: wd_i, wreg: wreg_i, reg_wdata: reg_wdata_i,
                       csr_type: csr_type_i, csr_waddr: csr_waddr_i,
                       csr_wdata: csr_wdata_i, csr_mcause: csr_mcause_i,
                       pc: pc_i, ebreak: ebreak_flag_i};
  end

  // Head outputs; enables are masked so an empty or halted buffer never writes.
  always_comb begin
    commit_pc_o  = head_s.pc;
    wd_o         = commit_valid_o && head_s.wd && (head_s.wreg != 5'd0);
    wreg_o       = head_s.wreg;
    wdata_o      = head_s.reg_wdata;
    csr_type_o   = head_s.csr_type & {3{commit_valid_o}};
    csr_waddr_o  = head_s.csr_waddr;
    csr_wdata_o  = head_s.csr_wdata;
    csr_mcause_o = head_s.csr_mcause;
    ebreak_o     = ebreak_q;
    retire_cnt_o = retire_cnt_q;
    fwd_hit_o    = fwd_hit_s;
    fwd_data_o   = fwd_data_s;
  end

  // Forwarding: walk oldest to youngest so the youngest valid match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic             match;
    fwd_hit_s  = 1'b0;
    fwd_data_s = '0;
    idx        = rd_ptr_q;
    match      = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx        = rd_ptr_q + PTR_W'(k);
      match      = (CNT_W'(k) < count_q) && (state_q == ST_RUN) && buf_q[idx].wd &&
                   (buf_q[idx].wreg == fwd_raddr_i) && (buf_q[idx].wreg != 5'd0);
      fwd_hit_s  = fwd_hit_s | match;
      fwd_data_s = match ? buf_q[idx].reg_wdata : fwd_data_s;
    end
  end

  // Next-state for storage, pointers, occupancy, retire counter and halt FSM.
  always_comb begin
    buf_d = buf_q;
    if (enq_s) begin
      buf_d[wr_ptr_q] = in_entry_s;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (deq_s) begin
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
      retire_cnt_d = retire_cnt_q + CNT_LEN'(1);
    end else begin
      rd_ptr_d     = rd_ptr_q;
      retire_cnt_d = retire_cnt_q;
    end
    case ({enq_s, deq_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    case (state_q)
      ST_RUN: begin
        if (deq_s && head_s.ebreak) begin
          state_d  = ST_HALT;
          ebreak_d = 1'b1;
        end else begin
          state_d  = ST_RUN;
          ebreak_d = 1'b0;
        end
      end
      ST_HALT: begin
        state_d  = ST_HALT;
        ebreak_d = 1'b0;
      end
      default: begin
        state_d  = ST_HALT;
        ebreak_d = 1'b0;
      end
    endcase
  end

  // State registers; reset discards every buffered entry immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= ST_RUN;
      ebreak_q     <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= buf_d[i];
      end
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      ebreak_q     <= ebreak_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060025_wbu_buf.sv
// Directed bench for ysyx_23060025_wbu_buf (DEPTH=2): reset, retire, back-pressure,
// qualification, forwarding priority and the ebreak halt.
module tb_ysyx_23060025_wbu_buf;

  logic        clock;
  logic        reset;
  logic        ms_to_ws_valid;
  logic        ws_allowin_o;
  logic        wd_i;
  logic [4:0]  wreg_i;
  logic [31:0] reg_wdata_i;
  logic [2:0]  csr_type_i;
  logic [11:0] csr_waddr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_mcause_i;
  logic [31:0] pc_i;
  logic        ebreak_flag_i;
  logic        rf_ready_i;
  logic        commit_valid_o;
  logic [31:0] commit_pc_o;
  logic        wd_o;
  logic [4:0]  wreg_o;
  logic [31:0] wdata_o;
  logic [2:0]  csr_type_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic [31:0] csr_mcause_o;
  logic        ebreak_o;
  logic [63:0] retire_cnt_o;
  logic [4:0]  fwd_raddr_i;
  logic        fwd_hit_o;
  logic [31:0] fwd_data_o;

  int err_cnt = 0;
  int chk_cnt = 0;

  ysyx_23060025_wbu_buf #(.DATA_LEN(32), .ADDR_LEN(32), .DEPTH(2), .CNT_LEN(64)) dut (
    .clock(clock), .reset(reset),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin_o(ws_allowin_o),
    .wd_i(wd_i), .wreg_i(wreg_i), .reg_wdata_i(reg_wdata_i),
    .csr_type_i(csr_type_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
    .csr_mcause_i(csr_mcause_i), .pc_i(pc_i), .ebreak_flag_i(ebreak_flag_i),
    .rf_ready_i(rf_ready_i), .commit_valid_o(commit_valid_o), .commit_pc_o(commit_pc_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .csr_type_o(csr_type_o),
    .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o), .csr_mcause_o(csr_mcause_o),
    .ebreak_o(ebreak_o), .retire_cnt_o(retire_cnt_o),
    .fwd_raddr_i(fwd_raddr_i), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one LSU beat; CSR fields and PC are derived from the GPR fields.
  task automatic drive(input logic v, input logic [4:0] wreg, input logic [31:0] data,
                       input logic [2:0] ct, input logic eb);
    ms_to_ws_valid = v;
    wd_i           = 1'b1;
    wreg_i         = wreg;
    reg_wdata_i    = data;
    csr_type_i     = ct;
    csr_waddr_i    = 12'h300;
    csr_wdata_i    = data ^ 32'hFFFF_0000;
    csr_mcause_i   = 32'd0;
    pc_i           = 32'h8000_0000 + {25'd0, wreg, 2'b00};
    ebreak_flag_i  = eb;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 3'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    rf_ready_i  = 1'b0;
    fwd_raddr_i = 5'd0;
    idle();
    #3;
    chk("rst_cv", commit_valid_o, 1'b0);
    chk("rst_allowin", ws_allowin_o, 1'b1);
    chk("rst_cnt", retire_cnt_o, 64'd0);
    chk("rst_ebreak", ebreak_o, 1'b0);
    chk("rst_wd", wd_o, 1'b0);
    chk("rst_wdata", wdata_o, 32'd0);
    #9 reset = 1'b1;
    tick();

    // single write
    rf_ready_i = 1'b1;
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 3'd0, 1'b0);
    tick();
    idle();
    chk("sw_cv", commit_valid_o, 1'b1);
    chk("sw_wd", wd_o, 1'b1);
    chk("sw_wreg", wreg_o, 5'd5);
    chk("sw_wdata", wdata_o, 32'hDEAD_BEEF);
    chk("sw_pc", commit_pc_o, 32'h8000_0014);
    chk("sw_csrw", csr_wdata_o, 32'h2152_BEEF);
    chk("sw_cnt0", retire_cnt_o, 64'd0);
    tick();
    chk("sw_cnt1", retire_cnt_o, 64'd1);
    chk("sw_cv_empty", commit_valid_o, 1'b0);
    chk("sw_wd_empty", wd_o, 1'b0);

    // back-pressure and full
    rf_ready_i = 1'b0;
    drive(1'b1, 5'd1, 32'h0000_00A1, 3'd0, 1'b0);
    tick();
    chk("bp_allowin1", ws_allowin_o, 1'b1);
    drive(1'b1, 5'd2, 32'h0000_00B2, 3'd0, 1'b0);
    tick();
    idle();
    chk("bp_full", ws_allowin_o, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_wreg", wreg_o, 5'd1);
      chk("bp_hold_data", wdata_o, 32'h0000_00A1);
      chk("bp_hold_cv", commit_valid_o, 1'b1);
    end
    rf_ready_i = 1'b1;
    tick();
    chk("bp_headB", wreg_o, 5'd2);
    chk("bp_dataB", wdata_o, 32'h0000_00B2);
    chk("bp_allowin2", ws_allowin_o, 1'b1);
    chk("bp_cnt2", retire_cnt_o, 64'd2);
    tick();
    chk("bp_cv_empty", commit_valid_o, 1'b0);
    chk("bp_cnt3", retire_cnt_o, 64'd3);

    // forwarding priority
    rf_ready_i  = 1'b0;
    fwd_raddr_i = 5'd7;
    drive(1'b1, 5'd7, 32'd1, 3'd0, 1'b0);
    tick();
    drive(1'b1, 5'd7, 32'd2, 3'd0, 1'b0);
    #1;
    chk("fw_one_hit", fwd_hit_o, 1'b1);
    chk("fw_one_data", fwd_data_o, 32'd1);
    tick();
    idle();
    chk("fw_young_hit", fwd_hit_o, 1'b1);
    chk("fw_young_data", fwd_data_o, 32'd2);
    fwd_raddr_i = 5'd0;
    #1;
    chk("fw_x0_hit", fwd_hit_o, 1'b0);
    chk("fw_x0_data", fwd_data_o, 32'd0);
    fwd_raddr_i = 5'd9;
    #1;
    chk("fw_miss_hit", fwd_hit_o, 1'b0);
    fwd_raddr_i = 5'd7;
    rf_ready_i  = 1'b1;
    tick();
    chk("fw_after1_hit", fwd_hit_o, 1'b1);
    chk("fw_after1_data", fwd_data_o, 32'd2);
    tick();
    chk("fw_empty_hit", fwd_hit_o, 1'b0);
    chk("fw_cnt5", retire_cnt_o, 64'd5);

    // x0 and CSR qualification
    rf_ready_i  = 1'b0;
    fwd_raddr_i = 5'd0;
    drive(1'b1, 5'd0, 32'h55, 3'b010, 1'b0);
    tick();
    idle();
    chk("q_cv", commit_valid_o, 1'b1);
    chk("q_wd_x0", wd_o, 1'b0);
    chk("q_csr", csr_type_o, 3'b010);
    chk("q_fwd_x0", fwd_hit_o, 1'b0);
    rf_ready_i = 1'b1;
    tick();
    chk("q_csr_empty", csr_type_o, 3'b000);
    chk("q_wd_empty", wd_o, 1'b0);
    chk("q_cnt6", retire_cnt_o, 64'd6);

    // enqueue and retire in the same cycle at count 1
    drive(1'b1, 5'd3, 32'h33, 3'd0, 1'b0);
    tick();
    drive(1'b1, 5'd4, 32'h44, 3'd0, 1'b0);
    chk("ed_head3", wreg_o, 5'd3);
    tick();
    idle();
    chk("ed_head4", wreg_o, 5'd4);
    chk("ed_cv", commit_valid_o, 1'b1);
    chk("ed_cnt7", retire_cnt_o, 64'd7);
    chk("ed_allowin", ws_allowin_o, 1'b1);
    tick();
    chk("ed_cnt8", retire_cnt_o, 64'd8);
    chk("ed_cv_empty", commit_valid_o, 1'b0);

    // reset with pending entries
    rf_ready_i  = 1'b0;
    fwd_raddr_i = 5'd11;
    drive(1'b1, 5'd11, 32'hBB, 3'd0, 1'b0);
    tick();
    drive(1'b1, 5'd12, 32'hCC, 3'd0, 1'b0);
    tick();
    idle();
    chk("rp_full", ws_allowin_o, 1'b0);
    #3 reset = 1'b0;
    #1;
    chk("rp_cv", commit_valid_o, 1'b0);
    chk("rp_allowin", ws_allowin_o, 1'b1);
    chk("rp_cnt", retire_cnt_o, 64'd0);
    chk("rp_wdata", wdata_o, 32'd0);
    chk("rp_fwd", fwd_hit_o, 1'b0);
    #2 reset = 1'b1;
    tick();

    // ebreak halt
    rf_ready_i  = 1'b1;
    fwd_raddr_i = 5'd10;
    drive(1'b1, 5'd9, 32'h99, 3'd0, 1'b1);
    tick();
    drive(1'b1, 5'd10, 32'hAA, 3'd0, 1'b0);
    chk("eb_cv", commit_valid_o, 1'b1);
    chk("eb_pulse_pre", ebreak_o, 1'b0);
    tick();
    idle();
    chk("eb_pulse", ebreak_o, 1'b1);
    chk("eb_cnt", retire_cnt_o, 64'd1);
    chk("eb_allowin", ws_allowin_o, 1'b0);
    chk("eb_cv_halt", commit_valid_o, 1'b0);
    chk("eb_wd_halt", wd_o, 1'b0);
    chk("eb_fwd_halt", fwd_hit_o, 1'b0);
    tick();
    chk("eb_pulse_end", ebreak_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("eb_sticky_cnt", retire_cnt_o, 64'd1);
      chk("eb_sticky_cv", commit_valid_o, 1'b0);
      chk("eb_sticky_allowin", ws_allowin_o, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ysyx_23060025_wbu_buf.md
Name: ysyx_23060025_wbu_buf

Overview:
Parametrised writeback unit between the LSU and the register file/CSR unit. It replaces the single-register writeback with a DEPTH-entry in-order buffer and a real valid/ready handshake on both sides. It also provides bypass forwarding of buffered results, a retired-instruction counter, and a sticky halt on ebreak.

Parameters:
DATA_LEN, 32, width of GPR/CSR data and mcause
ADDR_LEN, 32, width of PC
DEPTH, 2, buffer entries; power of two, >= 2
CNT_LEN, 64, width of retire counter

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
ms_to_ws_valid  in  1  LSU presents an instruction
ws_allowin_o  out  1  buffer can accept this cycle
wd_i  in  1  GPR write enable
wreg_i  in  5  GPR destination
reg_wdata_i  in  DATA_LEN  GPR write data
csr_type_i  in  3  CSR op type (0 = none)
csr_waddr_i  in  12  CSR address
csr_wdata_i  in  DATA_LEN  CSR write data
csr_mcause_i  in  DATA_LEN  mcause value
pc_i  in  ADDR_LEN  instruction PC
ebreak_flag_i  in  1  instruction is ebreak
rf_ready_i  in  1  RF/CSR side accepts head entry
commit_valid_o  out  1  head entry valid
commit_pc_o  out  ADDR_LEN  head PC
wd_o  out  1  GPR write enable (qualified)
wreg_o  out  5  head destination
wdata_o  out  DATA_LEN  head GPR data
csr_type_o  out  3  head CSR type (qualified)
csr_waddr_o  out  12  head CSR address
csr_wdata_o  out  DATA_LEN  head CSR data
csr_mcause_o  out  DATA_LEN  head mcause
ebreak_o  out  1  one-cycle pulse when an ebreak retires
retire_cnt_o  out  CNT_LEN  retired-instruction count
fwd_raddr_i  in  5  forwarding query register
fwd_hit_o  out  1  buffered entry will write fwd_raddr_i
fwd_data_o  out  DATA_LEN  youngest matching data

Behaviour:
- Reset (reset=0, async): pointers/count=0, state=RUN, retire_cnt_o=0, ebreak_o=0. All entry fields clear. All outputs above read 0.
- ws_allowin_o = (state==RUN) && (count<DEPTH). It depends only on registered state, with no combinational path from rf_ready_i.
- Enqueue when ms_to_ws_valid && ws_allowin_o. The write pointer advances modulo DEPTH.
- commit_valid_o = (count!=0) && (state==RUN). The head outputs are driven from the entry at the read pointer.
- wd_o = commit_valid_o && head.wd && (head.wreg!=0).
- csr_type_o = head.csr_type & {3{commit_valid_o}}.
- The other head data outputs show raw entry contents. They are don't-care when commit_valid_o=0.
- Dequeue (retire) when commit_valid_o && rf_ready_i. The read pointer advances modulo DEPTH and retire_cnt_o increments by 1, wrapping at 2^CNT_LEN.
- Latency: an entry enqueued into an empty buffer at edge N is visible on the head outputs after edge N. It can retire at edge N+1 at the earliest.
- Enqueue and dequeue in the same cycle: count is unchanged. This is legal at any count below DEPTH. At full, no enqueue occurs.
- Back-pressure: with rf_ready_i=0, the head is held stable, unchanged, until it is accepted.
- State machine:
  - RUN -> HALT on the edge that retires an entry with ebreak set. ebreak_o=1 for exactly that following cycle.
  - HALT is sticky until reset: ws_allowin_o=0, commit_valid_o=0, and the counter is frozen.
  - Entries behind the ebreak are never retired.
- Forwarding (combinational): search valid entries from youngest to oldest for wd && wreg==fwd_raddr_i && wreg!=0.
  - On a match: fwd_hit_o=1 and fwd_data_o is that entry's data.
  - Otherwise fwd_hit_o=0 and fwd_data_o=0.
  - In HALT, fwd_hit_o=0.
- A reset asserted mid-operation discards all buffered entries immediately (async).

Test Plan:
- Reset with pending entries: fill 2 entries, assert reset=0 mid-cycle -> commit_valid_o=0, ws_allowin_o=1, retire_cnt_o=0 immediately.
- Single write: enqueue wreg=5, data=0xDEADBEEF, rf_ready_i=1 -> next cycle wd_o=1, wreg_o=5, wdata_o=0xDEADBEEF. The following cycle has retire_cnt_o=1 and commit_valid_o=0.
- Full/back-pressure (DEPTH=2): rf_ready_i=0, enqueue A then B -> ws_allowin_o=0 after 2nd edge. Head stays A for 5 cycles. Then set rf_ready_i=1 -> A then B retire on consecutive cycles, and ws_allowin_o=1 after the first retire.
- x0 and CSR qualification: enqueue wd=1, wreg=0, csr_type=3'b010 -> wd_o=0 and csr_type_o=3'b010 while at head. Both are 0 when the buffer is empty.
- Forwarding priority: buffer holds older wreg=7/data=1 and younger wreg=7/data=2. fwd_raddr_i=7 -> fwd_hit_o=1, fwd_data_o=2. fwd_raddr_i=0 -> fwd_hit_o=0.
- Ebreak halt: enqueue ebreak entry then a normal entry, rf_ready_i=1 -> ebreak_o high for one cycle and retire_cnt_o=1. Afterwards ws_allowin_o=0, commit_valid_o=0, and the second entry never retires until reset.
